// File: rtl/neuromorphic_wb_bridge_pkg.sv
// Shared definitions for the neuromorphic ReRAM Wishbone bridge: FSM states,
// register window offsets, STATUS bit positions and the timeout read word.
package neuromorphic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WREQ  = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } nm_state_e;

    // Byte offsets inside the two-word window (decoded from adr[2:0]).
    localparam logic [2:0] NM_DATA_OFS   = 3'h0;
    localparam logic [2:0] NM_STATUS_OFS = 3'h4;

    // STATUS register layout.
    localparam int NM_ST_PEND_MSB = 5;
    localparam int NM_ST_TIMEOUT  = 8;
    localparam int NM_ST_BUSY     = 9;
    localparam int NM_ST_OVERFLOW = 10;
    localparam int NM_ST_UNDERFLW = 11;

    // Returned on the bus when the macro never answers.
    localparam logic [31:0] NM_TIMEOUT_DATA = 32'hDEAD_0000;

    // Assemble the STATUS word; unused bits read as zero.
    function automatic logic [31:0] nm_status_word(
        input logic [5:0] pend,
        input logic       tmo,
        input logic       busy,
        input logic       ovf,
        input logic       udf
    );
        logic [31:0] w;
        w                      = 32'h0000_0000;
        w[NM_ST_PEND_MSB:0]    = pend;
        w[NM_ST_TIMEOUT]       = tmo;
        w[NM_ST_BUSY]          = busy;
        w[NM_ST_OVERFLOW]      = ovf;
        w[NM_ST_UNDERFLW]      = udf;
        return w;
    endfunction

endpackage

// File: rtl/neuromorphic_wb_bridge_if.sv
// Wishbone classic slave-side bus bundle for the neuromorphic bridge.
interface neuromorphic_wb_bridge_if;

    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_dat_o, wbs_ack_o
    );

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_dat_o, wbs_ack_o
    );

endinterface

// File: rtl/neuromorphic_wb_bridge_timeout_ctr.sv
// Per-request watchdog: cleared by load, counts while enabled, and flags
// expiry on the TIMEOUT_CYC-th enabled cycle. Saturates at the last count.
module neuromorphic_timeout_ctr #(
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic CLKin,
    input  logic RSTin,
    input  logic load,
    input  logic en,
    output logic expire
);

    localparam int              W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [W-1:0]    LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt_r;

    // Counter: restart on load, advance while the request is outstanding.
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LAST)) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = en && (cnt_r == LAST);

endmodule

// File: rtl/neuromorphic_wb_bridge.sv
// Wishbone classic slave fronting the 32x32 neuromorphic ReRAM macro.
// DATA (offset 0x0) turns bus cycles into macro EN/R_WB requests; STATUS
// (offset 0x4) exposes the pending-entry count and sticky error flags.
module neuromorphic_wb_bridge
    import neuromorphic_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          TIMEOUT_CYC = 1023,
    parameter int          DEPTH       = 32
) (
    input  logic                    CLKin,
    input  logic                    RSTin,
    neuromorphic_wb_bridge_if.slave wb,
    output logic                    EN,
    output logic                    R_WB,
    output logic [31:0]             DI,
    output logic [31:0]             AD,
    output logic [3:0]              SEL,
    input  logic [31:0]             DO,
    input  logic                    func_ack
);

    localparam logic [5:0] DEPTH_L = 6'(DEPTH);

    nm_state_e   state_r;
    logic [5:0]  pending_r;
    logic        tmo_r;
    logic        ovf_r;
    logic        udf_r;
    logic        ack_r;
    logic [31:0] dat_o_r;

    logic        hit_s;
    logic        is_status_s;
    logic [31:0] status_s;
    logic        ctr_load_s;
    logic        ctr_en_s;
    logic        expire_s;

    assign hit_s       = wb.wbs_cyc_i && wb.wbs_stb_i &&
                         (wb.wbs_adr_i[31:3] == BASE_ADDR[31:3]);
    assign is_status_s = ({wb.wbs_adr_i[2], 2'b00} == NM_STATUS_OFS);
    assign status_s    = nm_status_word(pending_r, tmo_r, (state_r != ST_IDLE),
                                        ovf_r, udf_r);

    // The watchdog is held cleared while idle so every request starts at zero.
    assign ctr_load_s  = (state_r == ST_IDLE);
    assign ctr_en_s    = (state_r == ST_WREQ) || (state_r == ST_RWAIT);

    neuromorphic_timeout_ctr #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .CLKin  (CLKin),
        .RSTin  (RSTin),
        .load   (ctr_load_s),
        .en     (ctr_en_s),
        .expire (expire_s)
    );

    assign wb.wbs_ack_o = ack_r;
    assign wb.wbs_dat_o = dat_o_r;

    // Bridge FSM: decode, macro request handshake, completion and status flags.
    always_ff @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            state_r   <= ST_IDLE;
            pending_r <= 6'd0;
            tmo_r     <= 1'b0;
            ovf_r     <= 1'b0;
            udf_r     <= 1'b0;
            ack_r     <= 1'b0;
            dat_o_r   <= 32'h0000_0000;
            EN        <= 1'b0;
            R_WB      <= 1'b0;
            DI        <= 32'h0000_0000;
            AD        <= 32'h0000_0000;
            SEL       <= 4'h0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ack_r <= 1'b0;
                    if (!hit_s) begin
                        state_r <= ST_IDLE;
                    end else if (is_status_s) begin
                        // Reads see the flags before this access's clear.
                        dat_o_r <= status_s;
                        if (wb.wbs_we_i) begin
                            tmo_r <= tmo_r & ~wb.wbs_dat_i[NM_ST_TIMEOUT];
                            ovf_r <= ovf_r & ~wb.wbs_dat_i[NM_ST_OVERFLOW];
                            udf_r <= udf_r & ~wb.wbs_dat_i[NM_ST_UNDERFLW];
                        end else begin
                            tmo_r <= tmo_r;
                        end
                        ack_r   <= 1'b1;
                        state_r <= ST_DONE;
                    end else if (wb.wbs_we_i) begin
                        if (pending_r == DEPTH_L) begin
                            // Macro queue full: a push would be dropped.
                            ovf_r   <= 1'b1;
                            ack_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            DI      <= wb.wbs_dat_i;
                            AD      <= wb.wbs_adr_i;
                            SEL     <= wb.wbs_sel_i;
                            R_WB    <= 1'b0;
                            EN      <= 1'b1;
                            state_r <= ST_WREQ;
                        end
                    end else begin
                        if (pending_r == 6'd0) begin
                            // Macro queue empty: it would ignore the read.
                            dat_o_r <= 32'h0000_0000;
                            udf_r   <= 1'b1;
                            ack_r   <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            AD      <= wb.wbs_adr_i;
                            SEL     <= wb.wbs_sel_i;
                            R_WB    <= 1'b1;
                            EN      <= 1'b1;
                            state_r <= ST_RWAIT;
                        end
                    end
                end

                ST_WREQ: begin
                    // Write request is a one-cycle pulse so the macro pushes once.
                    EN <= 1'b0;
                    if (func_ack) begin
                        pending_r <= pending_r + 6'd1;
                        ack_r     <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (expire_s) begin
                        tmo_r     <= 1'b1;
                        dat_o_r   <= NM_TIMEOUT_DATA;
                        ack_r     <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_WREQ;
                    end
                end

                ST_RWAIT: begin
                    // EN must stay high until the ack; dropping it aborts the read.
                    if (func_ack) begin
                        dat_o_r   <= DO;
                        EN        <= 1'b0;
                        pending_r <= pending_r - 6'd1;
                        ack_r     <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (expire_s) begin
                        EN        <= 1'b0;
                        tmo_r     <= 1'b1;
                        dat_o_r   <= NM_TIMEOUT_DATA;
                        ack_r     <= 1'b1;
                        state_r   <= ST_DONE;
                    end else begin
                        state_r   <= ST_RWAIT;
                    end
                end

                ST_DONE: begin
                    // Ack cycle; the stale strobe is ignored while here.
                    ack_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end

                default: begin
                    EN      <= 1'b0;
                    ack_r   <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuromorphic_wb_bridge.sv
// Randomised scoreboard bench for neuromorphic_wb_bridge with a behavioural
// macro stub and a queue-based reference model of the bridge's bookkeeping.
`timescale 1ns/1ps
module tb_neuromorphic_wb_bridge;
    import neuromorphic_pkg::*;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam int          TO_CYC = 63;
    localparam int          DEPTH  = 32;
    localparam int          RD_DLY = 44;
    localparam int          BUDGET = 200;

    logic        CLKin = 1'b0;
    logic        RSTin = 1'b0;
    logic        EN, R_WB;
    logic [31:0] DI, AD, DO;
    logic [3:0]  SEL;
    logic        func_ack;

    neuromorphic_wb_bridge_if wb();

    neuromorphic_wb_bridge #(
        .BASE_ADDR   (BASE),
        .TIMEOUT_CYC (TO_CYC),
        .DEPTH       (DEPTH)
    ) dut (
        .CLKin    (CLKin),
        .RSTin    (RSTin),
        .wb       (wb.slave),
        .EN       (EN),
        .R_WB     (R_WB),
        .DI       (DI),
        .AD       (AD),
        .SEL      (SEL),
        .DO       (DO),
        .func_ack (func_ack)
    );

    always #5 CLKin = ~CLKin;

    // ---------------- macro stub ----------------
    logic        mac_ack;
    logic [31:0] mac_do;
    int          rd_cnt;
    logic [7:0]  mac_q[$];
    bit          mute  = 1'b0;
    bit          stray = 1'b0;

    always @(posedge CLKin or negedge RSTin) begin
        if (!RSTin) begin
            mac_ack <= 1'b0;
            mac_do  <= 32'h0;
            rd_cnt  <= 0;
            mac_q.delete();
        end else begin
            mac_ack <= 1'b0;
            if (EN && !R_WB) begin
                if (!mute) begin
                    mac_q.push_back(DI[7:0]);
                    mac_ack <= 1'b1;
                end
                rd_cnt <= 0;
            end else if (EN && R_WB && !mac_ack) begin
                if (!mute && rd_cnt == RD_DLY - 1) begin
                    if (mac_q.size() > 0) begin
                        mac_do <= {24'h0, mac_q[0]};
                        void'(mac_q.pop_front());
                    end else begin
                        mac_do <= 32'h0;
                    end
                    mac_ack <= 1'b1;
                    rd_cnt  <= 0;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end else begin
                rd_cnt <= 0;
            end
        end
    end

    assign DO       = mac_do;
    assign func_ack = mac_ack | stray;

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [31:0] dat;
        bit          chk;
        string       name;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       mon_e;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         ref_pend = 0;
    bit         ref_to   = 1'b0;
    bit         ref_ovf  = 1'b0;
    bit         ref_udf  = 1'b0;
    logic [7:0] ref_q[$];

    function automatic logic [31:0] ref_status();
        logic [31:0] s;
        s = 32'h0;
        s = s | (32'(ref_pend) & 32'h3F);
        if (ref_to)  s = s | 32'h0000_0100;
        if (ref_ovf) s = s | 32'h0000_0400;
        if (ref_udf) s = s | 32'h0000_0800;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every bus ack consumes one expectation.
    always @(negedge CLKin) begin
        if (RSTin && wb.wbs_ack_o) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack with data %h, expected no ack", wb.wbs_dat_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.chk) check(mon_e.name, wb.wbs_dat_o, mon_e.dat);
            end
        end
    end

    // One bus cycle; checks ack latency and number of EN-high cycles (-1 = skip).
    task automatic bus(input string name, input logic we, input logic [31:0] adr,
                       input logic [31:0] dat, input logic [3:0] sel,
                       input int exp_lat, input int exp_en);
        int lat;
        int en_cnt;
        bit got;
        bit first;
        lat = 0; en_cnt = 0; got = 1'b0; first = 1'b1;
        @(posedge CLKin); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = we;
        wb.wbs_adr_i = adr;  wb.wbs_dat_i = dat;  wb.wbs_sel_i = sel;
        while (!got && lat < BUDGET) begin
            @(posedge CLKin);
            lat++;
            @(negedge CLKin);
            if (EN) begin
                if (first) begin
                    first = 1'b0;
                    check({name, "_rwb"}, {31'd0, R_WB}, {31'd0, ~we});
                    check({name, "_ad"}, AD, adr);
                    if (we) begin
                        check({name, "_di"}, DI, dat);
                        check({name, "_sel"}, {28'd0, SEL}, {28'd0, sel});
                    end
                end
                en_cnt++;
            end
            got = wb.wbs_ack_o;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_noack: got no ack in %0d cycles, expected ack", name, BUDGET);
        end else if (exp_lat >= 0) begin
            check({name, "_lat"}, 32'(lat), 32'(exp_lat));
        end
        if (exp_en >= 0) check({name, "_en"}, 32'(en_cnt), 32'(exp_en));
    endtask

    task automatic op_wr_data(input logic [31:0] d);
        exp_t e;
        logic [31:0] adr;
        logic [3:0]  sel;
        e.dat = 32'h0; e.chk = 1'b0; e.name = "wr_data";
        adr = BASE | 32'($urandom_range(0, 3));
        sel = 4'($urandom_range(1, 15));
        exp_q.push_back(e);
        if (ref_pend == DEPTH) begin
            ref_ovf = 1'b1;
            bus("wr_ovf", 1'b1, adr, d, sel, 1, 0);
        end else begin
            ref_q.push_back(d[7:0]);
            ref_pend++;
            bus("wr_data", 1'b1, adr, d, sel, 3, 1);
        end
    endtask

    task automatic op_rd_data();
        exp_t e;
        logic [31:0] adr;
        adr = BASE | 32'($urandom_range(0, 3));
        e.chk = 1'b1;
        if (ref_pend == 0) begin
            ref_udf = 1'b1;
            e.dat = 32'h0; e.name = "rd_udf_data";
            exp_q.push_back(e);
            bus("rd_udf", 1'b0, adr, 32'h0, 4'hF, 1, 0);
        end else begin
            e.dat = {24'h0, ref_q.pop_front()}; e.name = "rd_data";
            ref_pend--;
            exp_q.push_back(e);
            bus("rd_data", 1'b0, adr, 32'h0, 4'hF, -1, -1);
        end
    endtask

    task automatic op_rd_status();
        exp_t e;
        e.dat = ref_status(); e.chk = 1'b1; e.name = "status";
        exp_q.push_back(e);
        bus("rd_status", 1'b0, BASE + 32'h4 + 32'($urandom_range(0, 3)), 32'h0, 4'hF, 1, 0);
    endtask

    task automatic op_wr_status(input logic [31:0] d);
        exp_t e;
        e.dat = 32'h0; e.chk = 1'b0; e.name = "wr_status";
        if (d[8])  ref_to  = 1'b0;
        if (d[10]) ref_ovf = 1'b0;
        if (d[11]) ref_udf = 1'b0;
        exp_q.push_back(e);
        bus("wr_status", 1'b1, BASE + 32'h4, d, 4'hF, 1, 0);
    endtask

    task automatic op_rd_timeout();
        exp_t e;
        e.dat = 32'hDEAD_0000; e.chk = 1'b1; e.name = "tmo_data";
        ref_to = 1'b1;
        mute = 1'b1;
        exp_q.push_back(e);
        bus("rd_tmo", 1'b0, BASE, 32'h0, 4'hF, TO_CYC + 1, TO_CYC);
        mute = 1'b0;
    endtask

    int nohit_acks;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0; wb.wbs_we_i = 1'b0;
        wb.wbs_sel_i = 4'h0; wb.wbs_adr_i = 32'h0; wb.wbs_dat_i = 32'h0;

        // Reset values
        repeat (2) @(negedge CLKin);
        check("rst_en",   {31'd0, EN}, 32'd0);
        check("rst_rwb",  {31'd0, R_WB}, 32'd0);
        check("rst_ack",  {31'd0, wb.wbs_ack_o}, 32'd0);
        check("rst_dato", wb.wbs_dat_o, 32'h0);
        check("rst_di",   DI, 32'h0);
        check("rst_ad",   AD, 32'h0);
        check("rst_sel",  {28'd0, SEL}, 32'd0);
        RSTin = 1'b1;

        // Directed: write, status, read back
        op_wr_data(32'h0A30_00A5);
        op_rd_status();
        op_rd_data();
        op_rd_status();

        // Underflow and its clear
        op_rd_data();
        op_rd_status();
        op_wr_status(32'h0000_0800);
        op_rd_status();

        // Fill to DEPTH, then overflow
        for (int i = 0; i < DEPTH + 1; i++) op_wr_data($urandom);
        op_rd_status();
        op_wr_status(32'h0000_0400);

        // Random mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: op_wr_data($urandom);
                4, 5, 6:    op_rd_data();
                7, 8:       op_rd_status();
                default:    op_wr_status($urandom);
            endcase
        end
        op_rd_status();

        // Non-hit access is ignored
        @(posedge CLKin); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE + 32'h8;
        nohit_acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLKin);
            if (wb.wbs_ack_o) nohit_acks++;
        end
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        check("nohit_ack", 32'(nohit_acks), 32'd0);

        // Timeout on a silent macro (needs a pending entry)
        if (ref_pend == 0) op_wr_data($urandom);
        op_rd_timeout();
        op_rd_status();

        // Stray func_ack while idle changes nothing
        @(posedge CLKin); #1; stray = 1'b1;
        @(posedge CLKin); #1; stray = 1'b0;
        op_rd_status();
        op_wr_status(32'h0000_0D00);
        op_rd_status();

        // Reset in the middle of a read
        if (ref_pend == 0) op_wr_data($urandom);
        @(posedge CLKin); #1;
        wb.wbs_cyc_i = 1'b1; wb.wbs_stb_i = 1'b1; wb.wbs_we_i = 1'b0;
        wb.wbs_adr_i = BASE;
        repeat (10) @(posedge CLKin);
        #3;
        check("pre_rst_en", {31'd0, EN}, 32'd1);
        RSTin = 1'b0;
        #1;
        check("mid_rst_en",  {31'd0, EN}, 32'd0);
        check("mid_rst_ack", {31'd0, wb.wbs_ack_o}, 32'd0);
        wb.wbs_cyc_i = 1'b0; wb.wbs_stb_i = 1'b0;
        ref_pend = 0; ref_to = 1'b0; ref_ovf = 1'b0; ref_udf = 1'b0;
        ref_q.delete();
        repeat (2) @(negedge CLKin);
        RSTin = 1'b1;
        op_rd_status();
        op_rd_data();
        op_rd_status();

        repeat (3) @(negedge CLKin);
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
